// File: rtl/dmem_responder_if.sv
// Request/response bus between the execute stage (master) and the data-memory
// responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : funct3 size encoding (B/H/W/BU/HU)
//   req_wdata           : right-aligned store data
//   resp_valid/ready    : response handshake
//   resp_rdata          : extended load data, 0 for stores
//   resp_err            : misalignment error flag
interface dmem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_size;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, performs a single-cycle SRAM access with lane steering, then holds
// an extended response until the consumer takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : dmem_responder_if.slave (request/response handshakes)
// Build option:
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned H/HU/W accesses return
//   resp_err=1 with zero data and suppress the store; when undefined, the
//   address is forced to natural alignment and resp_err stays 0.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [2:0]        size;
    logic [ADDR_W+1:0] addr;
    logic [XLEN-1:0]   wdata;
  } req_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  logic [XLEN-1:0]  rd_word_q;

  logic              is_b_c;
  logic              is_h_c;
  logic              err_c;
  logic              mem_we_c;
  logic [1:0]        lane_c;
  logic [NB-1:0]     be_c;
  logic [XLEN-1:0]   wlanes_c;
  logic [ADDR_W-1:0] widx_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   load_c;
  logic              unused_addr_c;

  // Address bits above the SRAM index alias and are intentionally dropped.
  assign unused_addr_c = ^bus.req_addr[XLEN-1:ADDR_W+2];

  // Size class from the latched request; reserved encodings fall into W.
  assign is_b_c = (req_q.size[1:0] == 2'b00);
  assign is_h_c = (req_q.size[1:0] == 2'b01);
  assign widx_c = req_q.addr[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err_c = (is_h_c && req_q.addr[0]) ||
                 (!is_b_c && !is_h_c && (req_q.addr[1:0] != 2'b00));
`else
  assign err_c = 1'b0;
`endif

  assign mem_we_c = req_q.we && !err_c;

  // Lane steering: naturally aligned lane, replicated store data, byte enables.
  always_comb begin
    lane_c   = 2'b00;
    be_c     = '1;
    wlanes_c = req_q.wdata;
    if (is_b_c) begin
      lane_c   = req_q.addr[1:0];
      be_c     = NB'(1) << lane_c;
      wlanes_c = {NB{req_q.wdata[7:0]}};
    end else if (is_h_c) begin
      lane_c   = {req_q.addr[1], 1'b0};
      be_c     = NB'(3) << lane_c;
      wlanes_c = {(NB/2){req_q.wdata[15:0]}};
    end
  end

  // Load extraction and sign/zero extension from the registered SRAM word.
  always_comb begin
    byte_c = rd_word_q[{lane_c, 3'b000} +: 8];
    half_c = rd_word_q[{lane_c[1], 4'b0000} +: 16];
    load_c = rd_word_q;
    if (is_b_c) begin
      load_c = req_q.size[2] ? XLEN'(byte_c) : {{(XLEN-8){byte_c[7]}}, byte_c};
    end else if (is_h_c) begin
      load_c = req_q.size[2] ? XLEN'(half_c) : {{(XLEN-16){half_c[15]}}, half_c};
    end
  end

  // SRAM: contents are not reset; access happens only on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS) begin
      if (mem_we_c) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (be_c[i]) begin
            mem_q[widx_c][8*i +: 8] <= wlanes_c[8*i +: 8];
          end
        end
      end
      rd_word_q <= mem_q[widx_c];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        // req_ready_q is low for the first cycle after reset release.
        if (bus.req_valid && req_ready_q) begin
          req_d   = '{we:    bus.req_we,
                      size:  bus.req_size,
                      addr:  bus.req_addr[ADDR_W+1:0],
                      wdata: bus.req_wdata};
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        // First RESP cycle formats the read word; then hold until taken.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_c;
          resp_rdata_d = (req_q.we || err_c) ? '0 : load_c;
        end else if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases with literal expectations plus a
// randomized load/store stream, all checked every cycle against a byte-level
// reference model of the memory and the transaction timing.
module tb_dmem_responder;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic clk = 1'b0;
  logic rst;

  dmem_responder_if #(.XLEN(XLEN)) bus ();

  dmem_responder #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  mdl_mem [DEPTH] = '{default: 32'h0};
  bit           busy  = 1'b0;
  bit           armed = 1'b0;
  int unsigned  age   = 0;
  bit           m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [2:0]   m_size;
  logic [31:0]  exp_rdata;
  bit           exp_err;
  bit           exp_valid;
  int           n_mdl_resp = 0;
  int           n_drv_resp = 0;

  // Memory effect and expected response of the latched transaction.
  function automatic void model_commit();
    int unsigned idx, nbytes, sh;
    logic [31:0] w, mask, v;
    idx = (m_addr >> 2) % DEPTH;
    case (m_size)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      default:        nbytes = 4;
    endcase
    sh   = m_addr % 4;
    sh   = sh - (sh % nbytes);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((m_addr % nbytes) != 0) begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
      return;
    end
`endif
    w = mdl_mem[idx];
    if (m_we) begin
      w = (w & ~(mask << (8 * sh))) | ((m_wdata & mask) << (8 * sh));
      mdl_mem[idx] = w;
      exp_rdata = 32'h0;
    end else begin
      v = (w >> (8 * sh)) & mask;
      if (!m_size[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      exp_rdata = v;
    end
  endfunction

  // Compare DUT outputs to the model, then predict the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
      chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
      busy  = 1'b0;
      armed = 1'b0;
    end else begin
      exp_valid = busy && (age >= WS + 2);
      chk("req_ready",  32'(bus.req_ready),  32'(armed && !busy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("resp_rdata", bus.resp_rdata,    exp_rdata);
        chk("resp_err",   32'(bus.resp_err), 32'(exp_err));
      end
      if (busy) begin
        if (exp_valid && bus.resp_ready) begin
          busy = 1'b0;
          n_mdl_resp++;
        end else begin
          age++;
          if (age == WS + 1) model_commit();
        end
      end else if (armed && bus.req_valid) begin
        busy    = 1'b1;
        age     = 0;
        m_we    = bus.req_we;
        m_addr  = bus.req_addr;
        m_size  = bus.req_size;
        m_wdata = bus.req_wdata;
      end
      armed = 1'b1;
    end
  end

  // ---------------- driver ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    int n;
    n = 0;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_size  = sz;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("issue_timeout", 32'(n), 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // Scramble request fields: the latched copy must be used.
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_size  = 3'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic get_resp(input int stall, output logic [31:0] rd, output logic er,
                          output int unsigned lat);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", lat, 32'h0);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_drv_resp++;
  endtask

  task automatic do_txn(input logic we, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic er, output int unsigned lat);
    issue(we, a, sz, wd);
    get_resp(stall, rd, er, lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned lat;
    logic [31:0] a;

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    @(posedge clk); #1;
    chk("reset_req_ready",  32'(bus.req_ready),  32'h0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Give every SRAM word a known value.
    for (int i = 0; i < int'(DEPTH); i++) do_txn(1'b1, 32'(i * 4), SZ_W, 32'h0, 0, rd, er, lat);

    // Word store/load and response latency.
    do_txn(1'b1, 32'h10, SZ_W, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h10, SZ_W, 32'h0, 0, rd, er, lat);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_latency", lat, 32'(WS + 2));

    // Byte store, then sign/zero extended sub-word loads.
    do_txn(1'b1, 32'h11, SZ_B, 32'h80, 0, rd, er, lat);
    do_txn(1'b0, 32'h11, SZ_B, 32'h0, 0, rd, er, lat);
    chk("lb_11", rd, 32'hFFFFFF80);
    do_txn(1'b0, 32'h11, SZ_BU, 32'h0, 1, rd, er, lat);
    chk("lbu_11", rd, 32'h00000080);
    do_txn(1'b0, 32'h10, SZ_H, 32'h0, 0, rd, er, lat);
    chk("lh_10", rd, 32'hFFFF80EF);
    do_txn(1'b0, 32'h12, SZ_HU, 32'h0, 2, rd, er, lat);
    chk("lhu_12", rd, 32'h0000DEAD);

    // Top word and address aliasing.
    do_txn(1'b1, 32'hFFC, SZ_W, 32'h12345678, 0, rd, er, lat);
    do_txn(1'b0, 32'h1000, SZ_W, 32'h0, 0, rd, er, lat);
    chk("lw_1000_alias", rd, 32'h0);
    do_txn(1'b0, 32'hFFC, SZ_W, 32'h0, 0, rd, er, lat);
    chk("lw_ffc", rd, 32'h12345678);

    // Stalled response with a new request pending.
    issue(1'b0, 32'h10, SZ_W, 32'h0);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'hFFC;
    bus.req_size  = SZ_W;
    bus.req_valid = 1'b1;
    repeat (5) begin
      chk("stall_valid", 32'(bus.resp_valid), 32'h1);
      chk("stall_rdata", bus.resp_rdata, 32'hDEAD80EF);
      chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_drv_resp++;
    chk("ready_after_hs", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("accepted_after_hs", 32'(bus.req_ready), 32'h0);
    get_resp(0, rd, er, lat);
    chk("lw_ffc_after_stall", rd, 32'h12345678);

    // Reset during the wait of a store.
    do_txn(1'b1, 32'h20, SZ_W, 32'h01020304, 0, rd, er, lat);
    issue(1'b1, 32'h20, SZ_W, 32'hAAAA5555);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (4) begin
      chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);
      @(posedge clk); #1;
    end
    do_txn(1'b0, 32'h20, SZ_W, 32'h0, 0, rd, er, lat);
    chk("lw_20_after_abort", rd, 32'h01020304);

    // Misaligned accesses.
    do_txn(1'b0, 32'h13, SZ_W, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_13_err", 32'(er), 32'h1);
    chk("lw_13_rdata", rd, 32'h0);
`else
    chk("lw_13_err", 32'(er), 32'h0);
    chk("lw_13_rdata", rd, 32'hDEAD80EF);
`endif
    do_txn(1'b1, 32'h21, SZ_H, 32'hBEEF, 0, rd, er, lat);
    do_txn(1'b0, 32'h20, SZ_W, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("sh_21_unchanged", rd, 32'h01020304);
`else
    chk("sh_21_forced", rd, 32'h0102BEEF);
`endif

    // Randomized stream with clustered and aliased addresses.
    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 1)) << 12);
      if (i % 7 == 0) a = a | ($urandom & 32'hFFFF_0000);
      do_txn(1'($urandom), a, 3'($urandom_range(0, 7)), $urandom,
             int'($urandom_range(0, 3)), rd, er, lat);
      chk("rand_latency", lat, 32'(WS + 2));
    end

    repeat (3) @(posedge clk);
    chk("resp_count", 32'(n_drv_resp), 32'(n_mdl_resp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
